// File: rtl/instr_mem_loadable_if.sv
// Fetch and boot-loader bus of the loadable instruction memory.
// The memory side uses the slave modport; the PC/IF stage and UART loader drive the master side.
interface instr_mem_loadable_if #(
  parameter int unsigned ADDR_BITS = 6
) ();
  logic                 fetch_en;
  logic [31:0]          fetch_addr;
  logic [31:0]          fetch_data;
  logic                 fetch_valid;
  logic                 fetch_fault;
  logic                 load_start;
  logic                 load_stop;
  logic [7:0]           load_byte;
  logic                 load_byte_valid;
  logic                 load_busy;
  logic                 load_done;
  logic [ADDR_BITS:0]   load_count;

  modport slave (
    input  fetch_en, fetch_addr, load_start, load_stop, load_byte, load_byte_valid,
    output fetch_data, fetch_valid, fetch_fault, load_busy, load_done, load_count
  );

  modport master (
    output fetch_en, fetch_addr, load_start, load_stop, load_byte, load_byte_valid,
    input  fetch_data, fetch_valid, fetch_fault, load_busy, load_done, load_count
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Instruction memory with a registered word fetch port and a byte-serial loader
// that assembles little-endian words from the UART and writes them sequentially.
module instr_mem_loadable #(
  parameter int unsigned ADDR_BITS = 6,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_mem_loadable_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned CNT_W = ADDR_BITS + 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [31:0]          mem [DEPTH];

  logic [0:0]           state, state_nx;
  logic [1:0]           byte_idx, byte_idx_nx;
  logic [31:0]          asm_word, asm_nx;
  logic [31:0]          fetch_data_nx;
  logic                 fetch_valid_nx;
  logic                 fetch_fault_nx;
  logic                 load_busy_nx;
  logic                 load_done_nx;
  logic [CNT_W-1:0]     load_count_nx;
  logic                 mem_we;
  logic [31:0]          mem_wdata;
  logic [ADDR_BITS-1:0] idx;
  logic                 addr_fault;

  // Memory starts zero-filled; it is deliberately not touched by reset.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0000_0000;
  end

  assign idx        = bus.fetch_addr[ADDR_BITS+1:2];
  assign addr_fault = (bus.fetch_addr[1:0] != 2'b00) ||
                      ((bus.fetch_addr >> (ADDR_BITS + 2)) != 32'd0);

  // Next-state and next-output logic.
  always_comb begin
    state_nx       = state;
    byte_idx_nx    = byte_idx;
    asm_nx         = asm_word;
    fetch_data_nx  = bus.fetch_data;
    fetch_valid_nx = 1'b0;
    fetch_fault_nx = 1'b0;
    load_count_nx  = bus.load_count;
    mem_we         = 1'b0;
    mem_wdata      = {bus.load_byte, asm_word[23:0]};

    case (state)
      ST_RUN: begin
        if (bus.fetch_en) begin
          fetch_valid_nx = 1'b1;
          fetch_fault_nx = addr_fault;
          fetch_data_nx  = addr_fault ? NOP_WORD : mem[idx];
        end
        if (bus.load_start) begin
          state_nx      = ST_LOAD;
          load_count_nx = '0;
          byte_idx_nx   = 2'd0;
        end
      end
      default: begin
        if (bus.load_byte_valid) begin
          asm_nx[{byte_idx, 3'b000} +: 8] = bus.load_byte;
          byte_idx_nx                     = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            mem_we        = 1'b1;
            load_count_nx = bus.load_count + CNT_W'(1);
          end
        end
        // A byte arriving with stop is accepted first; any partial word is dropped.
        if (bus.load_stop || (load_count_nx == CNT_W'(DEPTH))) begin
          state_nx    = ST_RUN;
          byte_idx_nx = 2'd0;
        end
      end
    endcase

    load_busy_nx = (state_nx == ST_LOAD);
    load_done_nx = (state == ST_LOAD) && (state_nx == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_RUN;
      byte_idx        <= 2'd0;
      asm_word        <= 32'h0000_0000;
      bus.fetch_data  <= NOP_WORD;
      bus.fetch_valid <= 1'b0;
      bus.fetch_fault <= 1'b0;
      bus.load_busy   <= 1'b0;
      bus.load_done   <= 1'b0;
      bus.load_count  <= '0;
    end else begin
      state           <= state_nx;
      byte_idx        <= byte_idx_nx;
      asm_word        <= asm_nx;
      bus.fetch_data  <= fetch_data_nx;
      bus.fetch_valid <= fetch_valid_nx;
      bus.fetch_fault <= fetch_fault_nx;
      bus.load_busy   <= load_busy_nx;
      bus.load_done   <= load_done_nx;
      bus.load_count  <= load_count_nx;
    end
  end

  // Loader write port; the write address is the word count before increment.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[bus.load_count[ADDR_BITS-1:0]] <= mem_wdata;
    end
  end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: a 64-word instance and a 4-word instance
// exercising fetch, stall, fault, load, partial load, full load and mid-load reset.
module tb_instr_mem_loadable;
  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } fexp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fexp_t q6[$];
  fexp_t q2[$];
  int    dq6[$];
  int    dq2[$];
  fexp_t e6;
  fexp_t e2;
  int    d6;
  int    d2;

  instr_mem_loadable_if #(.ADDR_BITS(6)) b6 ();
  instr_mem_loadable_if #(.ADDR_BITS(2)) b2 ();

  instr_mem_loadable #(.ADDR_BITS(6), .INIT_FILE(""), .NOP_WORD(32'h0000_0000)) dut6 (
    .clk(clk), .reset(reset), .bus(b6.slave)
  );
  instr_mem_loadable #(.ADDR_BITS(2), .INIT_FILE(""), .NOP_WORD(32'hDEAD_0000)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor for the 64-word instance: fetch results and load_done pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (b6.fetch_valid) begin
        checks++;
        if (q6.size() == 0) begin
          errors++;
          $display("FAIL fetch6_unexpected: got data %h fault %b, expected no valid", b6.fetch_data, b6.fetch_fault);
        end else begin
          e6 = q6.pop_front();
          if (b6.fetch_data !== e6.data || b6.fetch_fault !== e6.fault) begin
            errors++;
            $display("FAIL fetch6: got data %h fault %b expected data %h fault %b",
                     b6.fetch_data, b6.fetch_fault, e6.data, e6.fault);
          end
        end
      end
      if (b6.load_done) begin
        checks++;
        if (dq6.size() == 0) begin
          errors++;
          $display("FAIL done6_unexpected: got load_done count %0d, expected no pulse", b6.load_count);
        end else begin
          d6 = dq6.pop_front();
          if (b6.load_count !== 7'(d6) || b6.load_busy !== 1'b0) begin
            errors++;
            $display("FAIL done6: got count %0d busy %b expected count %0d busy 0", b6.load_count, b6.load_busy, d6);
          end
        end
      end
    end
  end

  // Monitor for the 4-word instance.
  always @(negedge clk) begin
    if (reset) begin
      if (b2.fetch_valid) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL fetch2_unexpected: got data %h fault %b, expected no valid", b2.fetch_data, b2.fetch_fault);
        end else begin
          e2 = q2.pop_front();
          if (b2.fetch_data !== e2.data || b2.fetch_fault !== e2.fault) begin
            errors++;
            $display("FAIL fetch2: got data %h fault %b expected data %h fault %b",
                     b2.fetch_data, b2.fetch_fault, e2.data, e2.fault);
          end
        end
      end
      if (b2.load_done) begin
        checks++;
        if (dq2.size() == 0) begin
          errors++;
          $display("FAIL done2_unexpected: got load_done count %0d, expected no pulse", b2.load_count);
        end else begin
          d2 = dq2.pop_front();
          if (b2.load_count !== 3'(d2) || b2.load_busy !== 1'b0) begin
            errors++;
            $display("FAIL done2: got count %0d busy %b expected count %0d busy 0", b2.load_count, b2.load_busy, d2);
          end
        end
      end
    end
  end

  task automatic fetch6(input logic [31:0] a, input logic [31:0] d, input logic f);
    b6.fetch_en   = 1'b1;
    b6.fetch_addr = a;
    q6.push_back('{data: d, fault: f});
    @(posedge clk); #1;
    b6.fetch_en = 1'b0;
  endtask

  task automatic fetch2(input logic [31:0] a, input logic [31:0] d, input logic f);
    b2.fetch_en   = 1'b1;
    b2.fetch_addr = a;
    q2.push_back('{data: d, fault: f});
    @(posedge clk); #1;
    b2.fetch_en = 1'b0;
  endtask

  task automatic start6();
    b6.load_start = 1'b1;
    @(posedge clk); #1;
    b6.load_start = 1'b0;
    chk("busy6_after_start", 32'(b6.load_busy), 32'd1);
  endtask

  task automatic byte6(input logic [7:0] v, input logic stop);
    b6.load_byte       = v;
    b6.load_byte_valid = 1'b1;
    b6.load_stop       = stop;
    @(posedge clk); #1;
    b6.load_byte_valid = 1'b0;
    b6.load_stop       = 1'b0;
  endtask

  task automatic byte2(input logic [7:0] v);
    b2.load_byte       = v;
    b2.load_byte_valid = 1'b1;
    @(posedge clk); #1;
    b2.load_byte_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    b6.fetch_en = 1'b0; b6.fetch_addr = 32'h0; b6.load_start = 1'b0; b6.load_stop = 1'b0;
    b6.load_byte = 8'h00; b6.load_byte_valid = 1'b0;
    b2.fetch_en = 1'b0; b2.fetch_addr = 32'h0; b2.load_start = 1'b0; b2.load_stop = 1'b0;
    b2.load_byte = 8'h00; b2.load_byte_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch_data6", b6.fetch_data, 32'h0000_0000);
    chk("rst_fetch_data2", b2.fetch_data, 32'hDEAD_0000);
    chk("rst_valid6", 32'(b6.fetch_valid), 32'd0);
    chk("rst_fault6", 32'(b6.fetch_fault), 32'd0);
    chk("rst_busy6", 32'(b6.load_busy), 32'd0);
    chk("rst_done6", 32'(b6.load_done), 32'd0);
    chk("rst_count6", 32'(b6.load_count), 32'd0);
    chk("rst_count2", 32'(b2.load_count), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Program word0=20080005, word1=0; stray fetch and load_start during load are ignored.
    start6();
    byte6(8'h05, 1'b0);
    byte6(8'h00, 1'b0);
    b6.fetch_en = 1'b1; b6.fetch_addr = 32'h0; b6.load_start = 1'b1;
    byte6(8'h08, 1'b0);
    b6.fetch_en = 1'b0; b6.load_start = 1'b0;
    byte6(8'h20, 1'b0);
    chk("busy6_mid_load", 32'(b6.load_busy), 32'd1);
    chk("count6_mid_load", 32'(b6.load_count), 32'd1);
    byte6(8'h00, 1'b0);
    byte6(8'h00, 1'b0);
    byte6(8'h00, 1'b0);
    dq6.push_back(2);
    byte6(8'h00, 1'b1);
    chk("busy6_after_stop", 32'(b6.load_busy), 32'd0);
    @(posedge clk); #1;
    chk("done6_one_cycle", 32'(b6.load_done), 32'd0);

    fetch6(32'h0, 32'h2008_0005, 1'b0);
    fetch6(32'h4, 32'h0000_0000, 1'b0);

    // Stall: data holds, valid low.
    fetch6(32'h0, 32'h2008_0005, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_valid6", 32'(b6.fetch_valid), 32'd0);
      chk("stall_data6", b6.fetch_data, 32'h2008_0005);
    end

    fetch6(32'h2, 32'h0000_0000, 1'b1);
    fetch6(32'h100, 32'h0000_0000, 1'b1);
    fetch6(32'hFC, 32'h0000_0000, 1'b0);

    // load_stop in RUN is ignored.
    b6.load_stop = 1'b1;
    @(posedge clk); #1;
    b6.load_stop = 1'b0;
    chk("stop_in_run_busy6", 32'(b6.load_busy), 32'd0);

    start6();
    byte6(8'h78, 1'b0); byte6(8'h56, 1'b0); byte6(8'h34, 1'b0); byte6(8'h12, 1'b0);
    byte6(8'hEF, 1'b0); byte6(8'hBE, 1'b0); byte6(8'hAD, 1'b0); byte6(8'hDE, 1'b0);
    chk("busy6_before_stop", 32'(b6.load_busy), 32'd1);
    dq6.push_back(2);
    b6.load_stop = 1'b1;
    @(posedge clk); #1;
    b6.load_stop = 1'b0;
    fetch6(32'h0, 32'h1234_5678, 1'b0);
    fetch6(32'h4, 32'hDEAD_BEEF, 1'b0);

    // Partial word at stop; a fetch issued with load_start is still serviced.
    b6.fetch_en = 1'b1; b6.fetch_addr = 32'h4;
    q6.push_back('{data: 32'hDEAD_BEEF, fault: 1'b0});
    start6();
    b6.fetch_en = 1'b0;
    byte6(8'h11, 1'b0); byte6(8'h22, 1'b0); byte6(8'h33, 1'b0); byte6(8'h44, 1'b0);
    byte6(8'hAA, 1'b0);
    dq6.push_back(1);
    byte6(8'hBB, 1'b1);
    chk("count6_partial", 32'(b6.load_count), 32'd1);
    fetch6(32'h4, 32'hDEAD_BEEF, 1'b0);
    fetch6(32'h0, 32'h4433_2211, 1'b0);

    // Full load of the 4-word instance, then an extra byte.
    b2.load_start = 1'b1;
    @(posedge clk); #1;
    b2.load_start = 1'b0;
    for (int i = 0; i < 15; i++) byte2(8'(i));
    chk("busy2_before_last", 32'(b2.load_busy), 32'd1);
    dq2.push_back(4);
    byte2(8'h0F);
    chk("busy2_full", 32'(b2.load_busy), 32'd0);
    chk("count2_full", 32'(b2.load_count), 32'd4);
    byte2(8'hFF);
    chk("busy2_extra", 32'(b2.load_busy), 32'd0);
    chk("count2_extra", 32'(b2.load_count), 32'd4);
    fetch2(32'h0, 32'h0302_0100, 1'b0);
    fetch2(32'h4, 32'h0706_0504, 1'b0);
    fetch2(32'hC, 32'h0F0E_0D0C, 1'b0);
    fetch2(32'h10, 32'hDEAD_0000, 1'b1);

    // Reset in the middle of a load.
    start6();
    byte6(8'h01, 1'b0); byte6(8'h02, 1'b0); byte6(8'h03, 1'b0); byte6(8'h04, 1'b0);
    byte6(8'h05, 1'b0);
    reset = 1'b0;
    #2;
    chk("midrst_busy6", 32'(b6.load_busy), 32'd0);
    chk("midrst_count6", 32'(b6.load_count), 32'd0);
    chk("midrst_data6", b6.fetch_data, 32'h0000_0000);
    @(posedge clk); #1;
    reset = 1'b1;
    fetch6(32'h0, 32'h0403_0201, 1'b0);
    fetch6(32'h4, 32'hDEAD_BEEF, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_fetch6", 32'(q6.size()), 32'd0);
    chk("pending_fetch2", 32'(q2.size()), 32'd0);
    chk("pending_done6", 32'(dq6.size()), 32'd0);
    chk("pending_done2", 32'(dq2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
